// File: rtl/hlsm_sched_core.sv
// hlsm_sched_core: computes x = (a*c) - (a+b), z = (a+c) + (a*c) and g = a<b
// under a fixed schedule. One shared adder/subtractor and one pipelined
// multiplier are used, behind a registered Start/Done/Busy handshake.
module hlsm_sched_core #(
    parameter int DATAWIDTH = 32,
    parameter int MUL_LAT   = 2,
    parameter int SIGNED    = 0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    output logic                 Done,
    output logic                 Busy,
    output logic [DATAWIDTH-1:0] x,
    output logic [DATAWIDTH-1:0] z,
    output logic                 g
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S0    = 3'd1,
        S1    = 3'd2,
        MWAIT = 3'd3,
        S2    = 3'd4,
        S3    = 3'd5,
        FIN   = 3'd6
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    state_t               state, state_nx;
    logic [DATAWIDTH-1:0] a_r, b_r, c_r;
    logic [DATAWIDTH-1:0] d_r, f_r, zrin_r, xi_r;
    logic                 g_r;
    logic [3:0]           cnt;
    logic [DATAWIDTH-1:0] add_a, add_b, add_res;
    logic                 add_sub;
    logic                 lt;
    logic [DATAWIDTH-1:0] mul_pipe [MUL_LAT];
    logic [MUL_LAT-1:0]   mul_vld;

    // State register
    always_ff @(posedge Clk) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic and operand steering for the single shared adder/subtractor
    always_comb begin
        state_nx = IDLE;
        add_a    = '0;
        add_b    = '0;
        add_sub  = 1'b0;
        case (state)
            IDLE:  state_nx = Start ? S0 : IDLE;
            S0: begin
                add_a    = a_r;
                add_b    = b_r;
                state_nx = S1;
            end
            S1: begin
                add_a    = a_r;
                add_b    = c_r;
                state_nx = (MUL_LAT > 1) ? MWAIT : S2;
            end
            // counter starts at MUL_LAT-1 and is checked before decrementing,
            // so MWAIT lasts MUL_LAT-1 cycles and S2 lands at launch+MUL_LAT+1
            MWAIT: state_nx = (cnt <= 4'd1) ? S2 : MWAIT;
            S2: begin
                add_a    = f_r;
                add_b    = d_r;
                add_sub  = 1'b1;
                state_nx = S3;
            end
            S3: begin
                add_a    = zrin_r;
                add_b    = f_r;
                state_nx = FIN;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        add_res = add_sub ? (add_a - add_b) : (add_a + add_b);
    end

    // Comparator for g, signedness fixed by parameter
    always_comb begin
        if (SIGNED != 0) lt = $signed(a_r) < $signed(b_r);
        else             lt = a_r < b_r;
    end

    // Multiplier pipeline: launched in S0, f registered MUL_LAT edges later
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            for (int unsigned i = 0; i < MUL_LAT; i++) mul_pipe[i] <= '0;
            mul_vld <= '0;
            f_r     <= '0;
        end else begin
            mul_pipe[0] <= a_r * c_r;
            mul_vld[0]  <= (state == S0);
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                mul_pipe[i] <= mul_pipe[i-1];
                mul_vld[i]  <= mul_vld[i-1];
            end
            if (mul_vld[MUL_LAT-1]) f_r <= mul_pipe[MUL_LAT-1];
        end
    end

    // Scheduled datapath registers and handshake outputs
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            a_r    <= '0;
            b_r    <= '0;
            c_r    <= '0;
            d_r    <= '0;
            zrin_r <= '0;
            xi_r   <= '0;
            g_r    <= 1'b0;
            cnt    <= '0;
            Done   <= 1'b0;
            Busy   <= 1'b0;
            x      <= '0;
            z      <= '0;
            g      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    a_r  <= a;
                    b_r  <= b;
                    c_r  <= c;
                    Busy <= 1'b1;
                end
                S0: begin
                    d_r <= add_res;
                    g_r <= lt;
                    cnt <= CNT_INIT;
                end
                S1:    zrin_r <= add_res;
                MWAIT: cnt    <= cnt - 4'd1;
                S2:    xi_r   <= add_res;
                S3: begin
                    x    <= xi_r;
                    z    <= add_res;
                    g    <= g_r;
                    Done <= 1'b1;
                end
                FIN: begin
                    Done <= 1'b0;
                    Busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hlsm_sched_core.sv
// tb_hlsm_sched_core: five parameterisations driven by shared stimulus.
// Expected results are queued per instance at accept and compared on Done.
module tb_hlsm_sched_core;

    typedef struct {
        logic [31:0] x;
        logic [31:0] z;
        logic        g;
        int          due;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [31:0] a, b, c;
    logic        done_w [5];
    logic        busy_w [5];
    logic        g_w    [5];
    logic [31:0] x_w    [5];
    logic [31:0] z_w    [5];
    logic [7:0]  x8, z8;

    exp_t        q [5][$];
    int          cnt [5];
    logic [31:0] lx [5];
    logic [31:0] lz [5];
    logic        lg [5];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 Clk = ~Clk;

    // 0: base, 1: signed compare, 2: 8-bit, 3: MUL_LAT=1, 4: MUL_LAT=8
    hlsm_sched_core #(.DATAWIDTH(32), .MUL_LAT(2), .SIGNED(0)) u_base (
        .Clk(Clk), .Rst(Rst), .Start(Start), .a(a), .b(b), .c(c),
        .Done(done_w[0]), .Busy(busy_w[0]), .x(x_w[0]), .z(z_w[0]), .g(g_w[0]));
    hlsm_sched_core #(.DATAWIDTH(32), .MUL_LAT(2), .SIGNED(1)) u_sgn (
        .Clk(Clk), .Rst(Rst), .Start(Start), .a(a), .b(b), .c(c),
        .Done(done_w[1]), .Busy(busy_w[1]), .x(x_w[1]), .z(z_w[1]), .g(g_w[1]));
    hlsm_sched_core #(.DATAWIDTH(8), .MUL_LAT(2), .SIGNED(0)) u_w8 (
        .Clk(Clk), .Rst(Rst), .Start(Start), .a(a[7:0]), .b(b[7:0]), .c(c[7:0]),
        .Done(done_w[2]), .Busy(busy_w[2]), .x(x8), .z(z8), .g(g_w[2]));
    hlsm_sched_core #(.DATAWIDTH(32), .MUL_LAT(1), .SIGNED(0)) u_l1 (
        .Clk(Clk), .Rst(Rst), .Start(Start), .a(a), .b(b), .c(c),
        .Done(done_w[3]), .Busy(busy_w[3]), .x(x_w[3]), .z(z_w[3]), .g(g_w[3]));
    hlsm_sched_core #(.DATAWIDTH(32), .MUL_LAT(8), .SIGNED(0)) u_l8 (
        .Clk(Clk), .Rst(Rst), .Start(Start), .a(a), .b(b), .c(c),
        .Done(done_w[4]), .Busy(busy_w[4]), .x(x_w[4]), .z(z_w[4]), .g(g_w[4]));

    assign x_w[2] = {24'd0, x8};
    assign z_w[2] = {24'd0, z8};

    function automatic int lat_of(input int i);
        case (i)
            3:       return 1;
            4:       return 8;
            default: return 2;
        endcase
    endfunction

    function automatic exp_t model(input int i, input logic [31:0] ai,
                                   input logic [31:0] bi, input logic [31:0] ci);
        exp_t        e;
        logic [31:0] m, sb, aa, bb, cc, d, f, zr;
        m  = (i == 2) ? 32'h0000_00FF : 32'hFFFF_FFFF;
        sb = (i == 2) ? 32'h0000_0080 : 32'h8000_0000;
        aa = ai & m;
        bb = bi & m;
        cc = ci & m;
        d  = (aa + bb) & m;
        f  = (aa * cc) & m;
        zr = (aa + cc) & m;
        e.x = (f - d) & m;
        e.z = (zr + f) & m;
        e.g = (i == 1) ? ((aa ^ sb) < (bb ^ sb)) : (aa < bb);
        e.due = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference model: tracks per-instance accept windows at each rising edge
    initial forever begin
        @(posedge Clk);
        cyc++;
        for (int i = 0; i < 5; i++) begin
            if (!Rst) begin
                q[i].delete();
                cnt[i] = 0;
                lx[i]  = '0;
                lz[i]  = '0;
                lg[i]  = 1'b0;
            end else begin
                if (cnt[i] > 0) cnt[i]--;
                if (cnt[i] == 0 && Start) begin
                    exp_t e;
                    e     = model(i, a, b, c);
                    e.due = cyc + 3 + lat_of(i);
                    q[i].push_back(e);
                    cnt[i] = lat_of(i) + 5;
                end
            end
        end
    end

    // Monitor: compares outputs on the falling edge
    initial forever begin
        @(negedge Clk);
        for (int i = 0; i < 5; i++) begin
            if (done_w[i] === 1'b1) begin
                if (q[i].size() == 0) begin
                    chk($sformatf("spurious_done[%0d]", i), 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q[i].pop_front();
                    chk($sformatf("done_cycle[%0d]", i), cyc, e.due);
                    chk($sformatf("x[%0d]", i), x_w[i], e.x);
                    chk($sformatf("z[%0d]", i), z_w[i], e.z);
                    chk($sformatf("g[%0d]", i), {31'd0, g_w[i]}, {31'd0, e.g});
                    lx[i] = e.x;
                    lz[i] = e.z;
                    lg[i] = e.g;
                end
            end else begin
                chk($sformatf("done_low[%0d]", i), {31'd0, done_w[i]}, 32'd0);
                if (q[i].size() > 0 && q[i][0].due < cyc) begin
                    chk($sformatf("done_timeout[%0d]", i), cyc, q[i][0].due);
                    void'(q[i].pop_front());
                end
                chk($sformatf("x_hold[%0d]", i), x_w[i], lx[i]);
                chk($sformatf("z_hold[%0d]", i), z_w[i], lz[i]);
                chk($sformatf("g_hold[%0d]", i), {31'd0, g_w[i]}, {31'd0, lg[i]});
            end
            chk($sformatf("busy[%0d]", i), {31'd0, busy_w[i]}, (cnt[i] >= 2) ? 32'd1 : 32'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // One-cycle Start pulse; operands are scrambled right after to prove capture
    task automatic pulse(input logic [31:0] ai, input logic [31:0] bi, input logic [31:0] ci);
        a = ai;
        b = bi;
        c = ci;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        a = $urandom;
        b = $urandom;
        c = $urandom;
    endtask

    initial begin
        Rst   = 1'b0;
        Start = 1'b0;
        a = '0;
        b = '0;
        c = '0;
        idle(3);
        Rst = 1'b1;
        idle(2);

        pulse(32'd5, 32'd3, 32'd4);
        idle(16);
        pulse(32'hFFFF_FFFE, 32'd3, 32'd4);
        idle(16);
        pulse(32'd200, 32'd100, 32'd3);
        idle(16);

        // Start while busy is ignored
        pulse(32'd5, 32'd3, 32'd4);
        idle(2);
        pulse(32'd7, 32'd9, 32'd11);
        idle(16);

        // Start held high: back-to-back runs with operands changing every cycle
        Start = 1'b1;
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = $urandom;
            c = $urandom;
            @(negedge Clk);
        end
        Start = 1'b0;
        idle(16);

        // Reset while the base instance sits in MWAIT aborts with no Done
        pulse(32'd5, 32'd3, 32'd4);
        idle(2);
        Rst = 1'b0;
        idle(1);
        Rst = 1'b1;
        idle(2);
        pulse(32'd5, 32'd3, 32'd4);
        idle(16);

        for (int n = 0; n < 6; n++) begin
            pulse($urandom, $urandom, $urandom);
            idle(14);
        end
        idle(4);

        for (int i = 0; i < 5; i++) chk($sformatf("drain[%0d]", i), q[i].size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
